// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Each port has a one-entry registered response buffer; results appear one cycle after acceptance.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [W-1:0]   req_a0,
  input  logic [W-1:0]   req_b0,
  input  logic [W-1:0]   req_a1,
  input  logic [W-1:0]   req_b1,
  input  logic [2:0]     req_op0,
  input  logic [2:0]     req_op1,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_result0,
  output logic [W-1:0]   rsp_result1,
  output logic           rsp_zero0,
  output logic           rsp_zero1,
  output logic [W-1:0]   SrcA,
  output logic [W-1:0]   SrcB,
  output logic [2:0]     ALUControl,
  input  logic [W-1:0]   ALUResult,
  input  logic           Zero,
  output logic [15:0]    op_count
);

  // Handshake: a request transfers on req_valid[i] && req_ready[i]; a response
  // leaves the buffer on rsp_valid[i] && rsp_ready[i]. Both may happen together.
  logic [1:0]   elig;
  logic [1:0]   grant;
  logic         last_grant_q, last_grant_d;
  logic [1:0]   rsp_valid_q, rsp_valid_d;
  logic [W-1:0] rsp_result0_q, rsp_result0_d;
  logic [W-1:0] rsp_result1_q, rsp_result1_d;
  logic         rsp_zero0_q, rsp_zero0_d;
  logic         rsp_zero1_q, rsp_zero1_d;
  logic [15:0]  op_count_q, op_count_d;

  // A port is eligible only when its buffer is empty or draining this cycle.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready) & {2{~reset}};

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = grant;

  always_comb begin
    SrcA       = '0;
    SrcB       = '0;
    ALUControl = 3'b000;
    if (grant[0]) begin
      SrcA       = req_a0;
      SrcB       = req_b0;
      ALUControl = req_op0;
    end else if (grant[1]) begin
      SrcA       = req_a1;
      SrcB       = req_b1;
      ALUControl = req_op1;
    end
  end

  always_comb begin
    rsp_valid_d   = rsp_valid_q & ~rsp_ready;
    rsp_result0_d = rsp_result0_q;
    rsp_result1_d = rsp_result1_q;
    rsp_zero0_d   = rsp_zero0_q;
    rsp_zero1_d   = rsp_zero1_q;
    last_grant_d  = last_grant_q;
    op_count_d    = op_count_q;
    if (grant[0]) begin
      rsp_valid_d[0] = 1'b1;
      rsp_result0_d  = ALUResult;
      rsp_zero0_d    = Zero;
    end
    if (grant[1]) begin
      rsp_valid_d[1] = 1'b1;
      rsp_result1_d  = ALUResult;
      rsp_zero1_d    = Zero;
    end
    if (grant != 2'b00) begin
      last_grant_d = grant[1];
      op_count_d   = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q   <= 2'b00;
      rsp_result0_q <= '0;
      rsp_result1_q <= '0;
      rsp_zero0_q   <= 1'b0;
      rsp_zero1_q   <= 1'b0;
      last_grant_q  <= 1'b1;
      op_count_q    <= 16'd0;
    end else begin
      rsp_valid_q   <= rsp_valid_d;
      rsp_result0_q <= rsp_result0_d;
      rsp_result1_q <= rsp_result1_d;
      rsp_zero0_q   <= rsp_zero0_d;
      rsp_zero1_q   <= rsp_zero1_d;
      last_grant_q  <= last_grant_d;
      op_count_q    <= op_count_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_result0 = rsp_result0_q;
  assign rsp_result1 = rsp_result1_q;
  assign rsp_zero0   = rsp_zero0_q;
  assign rsp_zero1   = rsp_zero1_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to the ALU-side ports.
module tb_alu_arbiter;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [W-1:0]   req_a0, req_b0, req_a1, req_b1;
  logic [2:0]     req_op0, req_op1;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_result0, rsp_result1;
  logic           rsp_zero0, rsp_zero1;
  logic [W-1:0]   SrcA, SrcB;
  logic [2:0]     ALUControl;
  logic [W-1:0]   ALUResult;
  logic           Zero;
  logic [15:0]    op_count;

  int n_tests = 0;
  int n_fail  = 0;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result0(rsp_result0), .rsp_result1(rsp_result1),
    .rsp_zero0(rsp_zero0), .rsp_zero1(rsp_zero1),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .ALUResult(ALUResult), .Zero(Zero),
    .op_count(op_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // External ALU: 011 is the unused code and returns 0.
  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      3'b000: ALUResult = SrcA & SrcB;
      3'b001: ALUResult = SrcA | SrcB;
      3'b010: ALUResult = SrcA + SrcB;
      3'b100: ALUResult = SrcA & ~SrcB;
      3'b101: ALUResult = SrcA | ~SrcB;
      3'b110: ALUResult = SrcA - SrcB;
      3'b111: ALUResult = ($signed(SrcA) < $signed(SrcB)) ? 32'd1 : 32'd0;
      default: ALUResult = '0;
    endcase
    Zero = (ALUResult == '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b00;
    req_a0 = 32'd5; req_b0 = 32'd3; req_op0 = 3'b010;
    req_a1 = 32'd1; req_b1 = 32'd1; req_op1 = 3'b010;
    step();
    step();
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    n_tests++; if (rsp_result0 !== 32'd0 || rsp_result1 !== 32'd0) begin n_fail++; $display("FAIL reset_results got %h/%h exp 0/0", rsp_result0, rsp_result1); end
    n_tests++; if (rsp_zero0 !== 1'b0 || rsp_zero1 !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b%b exp 00", rsp_zero0, rsp_zero1); end
    n_tests++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count got %0d exp 0", op_count); end
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    req_valid = 2'b00;
    #3 reset = 1'b0;
  endtask

  task automatic test_basic();
    req_valid = 2'b01; rsp_ready = 2'b00;
    req_a0 = 32'd5; req_b0 = 32'd3; req_op0 = 3'b010;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL basic_req_ready got %b exp 01", req_ready); end
    n_tests++; if (SrcA !== 32'd5 || SrcB !== 32'd3 || ALUControl !== 3'b010) begin n_fail++; $display("FAIL basic_alu_drive got %h %h %b exp 5 3 010", SrcA, SrcB, ALUControl); end
    step();
    n_tests++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL basic_rsp_valid got %b exp 01", rsp_valid); end
    n_tests++; if (rsp_result0 !== 32'd8 || rsp_zero0 !== 1'b0) begin n_fail++; $display("FAIL basic_result got %0d z%b exp 8 z0", rsp_result0, rsp_zero0); end
    n_tests++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL basic_op_count got %0d exp 1", op_count); end
    // buffer full and not draining: port 0 must be blocked, ALU idle
    n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL basic_blocked got %b exp 00", req_ready); end
    n_tests++; if (SrcA !== 32'd0 || SrcB !== 32'd0 || ALUControl !== 3'b000) begin n_fail++; $display("FAIL basic_idle_drive got %h %h %b exp 0 0 000", SrcA, SrcB, ALUControl); end
    req_valid = 2'b00; rsp_ready = 2'b01;
    step();
    n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL basic_pop got %b exp 00", rsp_valid); end
    n_tests++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL basic_idle_count got %0d exp 1", op_count); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_a0 = 32'h0000_00F0; req_b0 = 32'h0000_003C; req_op0 = 3'b000;
    req_a1 = 32'd7; req_b1 = 32'd7; req_op1 = 3'b110;
    exp_g = 2'b10;  // port 0 was granted last
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (req_ready !== exp_g) begin n_fail++; $display("FAIL alt_grant[%0d] got %b exp %b", i, req_ready, exp_g); end
      step();
      n_tests++; if (rsp_valid !== exp_g) begin n_fail++; $display("FAIL alt_rsp_valid[%0d] got %b exp %b", i, rsp_valid, exp_g); end
      if (exp_g == 2'b10) begin
        n_tests++; if (rsp_result1 !== 32'd0 || rsp_zero1 !== 1'b1) begin n_fail++; $display("FAIL alt_sub got %0d z%b exp 0 z1", rsp_result1, rsp_zero1); end
      end else begin
        n_tests++; if (rsp_result0 !== 32'h30 || rsp_zero0 !== 1'b0) begin n_fail++; $display("FAIL alt_and got %h z%b exp 30 z0", rsp_result0, rsp_zero0); end
      end
      exp_g = ~exp_g;
    end
    n_tests++; if (op_count !== 16'd5) begin n_fail++; $display("FAIL alt_op_count got %0d exp 5", op_count); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 2'b10;
    req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = 3'b010;
    req_a1 = 32'h0F; req_b1 = 32'hF0; req_op1 = 3'b001;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_grant[%0d] got %b exp 10", i, req_ready); end
      step();
      n_tests++; if (rsp_result0 !== 32'h30 || rsp_valid !== 2'b11) begin n_fail++; $display("FAIL bp_hold[%0d] got %h v%b exp 30 v11", i, rsp_result0, rsp_valid); end
      n_tests++; if (rsp_result1 !== 32'hFF) begin n_fail++; $display("FAIL bp_or[%0d] got %h exp ff", i, rsp_result1); end
    end
    rsp_ready = 2'b11;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL bp_release got %b exp 01", req_ready); end
    step();
    n_tests++; if (rsp_result0 !== 32'd2 || rsp_valid !== 2'b01) begin n_fail++; $display("FAIL bp_new got %0d v%b exp 2 v01", rsp_result0, rsp_valid); end
    n_tests++; if (op_count !== 16'd9) begin n_fail++; $display("FAIL bp_op_count got %0d exp 9", op_count); end
  endtask

  task automatic test_slt_unused();
    req_valid = 2'b01; rsp_ready = 2'b01;
    req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd1; req_op0 = 3'b111;
    step();
    n_tests++; if (rsp_result0 !== 32'd1 || rsp_zero0 !== 1'b0) begin n_fail++; $display("FAIL slt got %0d z%b exp 1 z0", rsp_result0, rsp_zero0); end
    req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = 3'b011;
    #1;
    n_tests++; if (ALUControl !== 3'b011) begin n_fail++; $display("FAIL op011_pass got %b exp 011", ALUControl); end
    step();
    n_tests++; if (rsp_result0 !== 32'd0 || rsp_zero0 !== 1'b1) begin n_fail++; $display("FAIL op011 got %0d z%b exp 0 z1", rsp_result0, rsp_zero0); end
    req_valid = 2'b00;
    step();
    n_tests++; if (rsp_valid !== 2'b00 || op_count !== 16'd11) begin n_fail++; $display("FAIL slt_idle got v%b c%0d exp v00 c11", rsp_valid, op_count); end
  endtask

  task automatic test_reset_mid();
    req_valid = 2'b11; rsp_ready = 2'b00;
    step();
    step();
    n_tests++; if (rsp_valid !== 2'b11) begin n_fail++; $display("FAIL mid_pre got %b exp 11", rsp_valid); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (rsp_valid !== 2'b00 || op_count !== 16'd0) begin n_fail++; $display("FAIL mid_async got v%b c%0d exp v00 c0", rsp_valid, op_count); end
    n_tests++; if (rsp_result0 !== 32'd0 || req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_clear got %h r%b exp 0 r00", rsp_result0, req_ready); end
    #2 reset = 1'b0;
    rsp_ready = 2'b11;
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_first got %b exp 01", req_ready); end
    step();
    n_tests++; if (rsp_valid !== 2'b01 || op_count !== 16'd1) begin n_fail++; $display("FAIL mid_after got v%b c%0d exp v01 c1", rsp_valid, op_count); end
  endtask

  task automatic test_wrap();
    req_valid = 2'b01; rsp_ready = 2'b11;
    req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = 3'b010;
    for (int i = 0; i < 65534; i++) step();
    n_tests++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_pre got %0d exp 65535", op_count); end
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (op_count !== 16'hFFFF || rsp_result0 !== 32'd3) begin n_fail++; $display("FAIL wrap_idle got c%0d r%0d exp c65535 r3", op_count, rsp_result0); end
    req_valid = 2'b11;
    #1;
    n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL wrap_resume got %b exp 10", req_ready); end
    step();
    n_tests++; if (op_count !== 16'd0) begin n_fail++; $display("FAIL wrap_zero got %0d exp 0", op_count); end
    #1;
    n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL wrap_next got %b exp 01", req_ready); end
    step();
    n_tests++; if (op_count !== 16'd1) begin n_fail++; $display("FAIL wrap_one got %0d exp 1", op_count); end
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_backpressure();
    test_slt_unused();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU (W-bit SrcA/SrcB, 3-bit ALUControl, ALUResult, Zero) between two requesters, e.g. the main datapath and an address/branch helper unit.
- Arbitration is round-robin with a valid/ready request handshake.
- Each port has its own one-entry registered response buffer with a valid/ready handshake.
- Sits between the requesters and the ALU instance; the ALU itself stays outside this block.

Parameters:
- W, 32, operand/result width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit i = port i.
- req_ready  out  2  per-port grant/accept; the request transfers when valid and ready are both 1.
- req_a0, req_b0  in  W each  port 0 operands.
- req_a1, req_b1  in  W each  port 1 operands.
- req_op0, req_op1  in  3 each  ALUControl code per port.
- rsp_valid  out  2  per-port response valid.
- rsp_ready  in  2  per-port response accept.
- rsp_result0, rsp_result1  out  W each  registered ALUResult per port.
- rsp_zero0, rsp_zero1  out  1 each  registered Zero per port.
- SrcA, SrcB  out  W each  to ALU.
- ALUControl  out  3  to ALU.
- ALUResult  in  W  from ALU.
- Zero  in  1  from ALU.
- op_count  out  16  number of ALU operations issued; wraps at 2^16.

Behaviour:
- Reset (async, immediate):
  - rsp_valid = 0; rsp_result* = 0; rsp_zero* = 0.
  - last_grant = 1, so port 0 wins the first contention.
  - op_count = 0.
  - Reset mid-operation drops any pending response. A request presented during reset is not accepted: req_ready = 0 while reset is high.
- Eligibility, per port i:
  - elig[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]).
  - A port cannot issue while its buffer is full and not draining.
  - Pop and new issue in the same cycle is allowed, giving back-to-back throughput.
- Grant (combinational, one-hot or zero):
  - Only one port eligible: grant it.
  - Both eligible: grant the port != last_grant.
  - None eligible: grant = 0.
  - req_ready = grant.
  - No combinational path from req_valid of one port to req_ready of the same port when it is ineligible: an ineligible port always sees req_ready = 0.
- ALU drive:
  - With a grant: SrcA/SrcB/ALUControl = the granted port's operands/op.
  - No grant: SrcA = 0, SrcB = 0, ALUControl = 3'b000.
- Capture, at the rising edge of clk, for a granted port g:
  - rsp_result_g <= ALUResult; rsp_zero_g <= Zero; rsp_valid[g] <= 1.
  - last_grant <= g; op_count <= op_count + 1 (mod 2^16).
  - Latency is exactly 1 cycle: request accepted in cycle N, rsp_valid high in cycle N+1.
- Response hold:
  - rsp_valid[i] is cleared on rsp_valid[i] && rsp_ready[i], unless port i is re-granted in the same cycle, in which case it stays 1 with the new data.
  - Result and zero are held stable while valid and not ready.
  - Buffer contents do not change when no capture occurs.
- last_grant updates only on an actual grant; an idle cycle preserves it.
- Total throughput: 1 op/cycle across both ports; each port sustains 1 op/cycle if it always drains.
- No combinational path from rsp_ready to rsp_valid or rsp data.
- All 8 ALUControl codes are passed through unchanged, including unused code 3'b011. The block does not interpret op codes.

Test Plan:
- Reset released, port 0 requests a=5, b=3, op=010 -> req_ready=2'b01 same cycle; next cycle rsp_valid[0]=1, rsp_result0=8, rsp_zero0=0, op_count=1.
- Both ports valid every cycle, both rsp_ready=1 -> grants alternate 01,10,01,10; port 1 op=110 with a=7, b=7 gives rsp_result1=0, rsp_zero1=1.
- Port 0 response pending with rsp_ready0=0, both requesting -> port 1 granted every cycle; port 0 req_ready=0 and rsp_result0 held; raising rsp_ready0 gives port 0 the grant that cycle.
- Port 0 op=111 with a=-1 (all ones), b=1 -> rsp_result0=1 (signed compare); op=011 -> rsp_result0=0, rsp_zero0=1.
- Reset asserted mid-stream with rsp_valid=2'b11 -> rsp_valid=0 and op_count=0 immediately without a clock; after release, port 0 wins the first contention.
- 65536 issued ops -> op_count wraps to 0; idle cycles in between do not change last_grant (verify the grant order resumes correctly).
